// File: rtl/pc_pkg.sv
// Shared program-counter definitions: FSM state encoding and default vectors/step
// used by pc_counter and the fetch stage.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        BUBBLE = 2'd2
    } pc_state_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;
    localparam int unsigned DEFAULT_STEP         = 4;

endpackage

// File: rtl/up_counter.sv
// Free-running wrap-around event counter with asynchronous active-low reset;
// counts one per cycle with inc=1.
module up_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pc_counter.sv
// Fetch program counter with stall, branch and trap redirect plus a retired-fetch counter.
// Optional target alignment check is enabled by defining PC_MISALIGN_CHECK_EN.
module pc_counter
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH        = 32,
    parameter int unsigned      STEP         = DEFAULT_STEP,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(DEFAULT_TRAP_VECTOR)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             load,
    input  logic [WIDTH-1:0] target,
    input  logic             trap,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] pc_plus_step,
    output logic             valid,
    output logic             misaligned,
    output logic [WIDTH-1:0] fetch_count
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    pc_state_t        state;
    logic             redirect;
    logic [WIDTH-1:0] redirect_pc;

    assign pc_plus_step = out + STEP_W;
    assign redirect     = trap | load;

`ifdef PC_MISALIGN_CHECK_EN
    logic bad_target;

    assign bad_target = (target % STEP_W) != '0;

    always_comb begin
        redirect_pc = target;
        if (trap || bad_target) begin
            redirect_pc = TRAP_VECTOR;
        end
    end

    // Redirects are ignored in BOOT, so the sticky flag only moves when one is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misaligned <= 1'b0;
        end else if (state != BOOT) begin
            if (trap) begin
                misaligned <= 1'b0;
            end else if (load) begin
                misaligned <= bad_target;
            end
        end
    end
`else
    always_comb begin
        redirect_pc = target;
        if (trap) begin
            redirect_pc = TRAP_VECTOR;
        end
    end

    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= BOOT;
            out   <= RESET_VECTOR;
            valid <= 1'b0;
        end else begin
            unique case (state)
                BOOT: begin
                    state <= RUN;
                    valid <= 1'b1;
                end
                RUN, BUBBLE: begin
                    if (redirect) begin
                        out   <= redirect_pc;
                        state <= BUBBLE;
                        valid <= 1'b0;
                    end else begin
                        if (state == RUN && !stall) begin
                            out <= pc_plus_step;
                        end
                        state <= RUN;
                        valid <= 1'b1;
                    end
                end
                default: begin
                    state <= BOOT;
                    valid <= 1'b0;
                end
            endcase
        end
    end

    up_counter #(
        .WIDTH(WIDTH)
    ) u_fetch_count (
        .clk  (clk),
        .reset(reset),
        .inc  (valid & ~stall),
        .count(fetch_count)
    );

endmodule

// File: tb/tb_pc_counter.sv
// Directed vector bench for pc_counter: table-driven main sequence plus
// hand-written wrap, misalignment and reset-in-bubble sequences.
module tb_pc_counter;

    logic        clk = 1'b1;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        load = 1'b0;
    logic        trap = 1'b0;
    logic [31:0] target = '0;
    logic [31:0] out, pc_plus_step, fetch_count;
    logic        valid, misaligned;

    logic        reset8 = 1'b0;
    logic        stall8 = 1'b0;
    logic        load8 = 1'b0;
    logic        trap8 = 1'b0;
    logic [7:0]  target8 = '0;
    logic [7:0]  out8, pc_plus_step8, fetch_count8;
    logic        valid8, misaligned8;

    int unsigned n_vec = 0;
    int unsigned n_miss = 0;

    always #5 clk = ~clk;

    pc_counter dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .load        (load),
        .target      (target),
        .trap        (trap),
        .out         (out),
        .pc_plus_step(pc_plus_step),
        .valid       (valid),
        .misaligned  (misaligned),
        .fetch_count (fetch_count)
    );

    pc_counter #(
        .WIDTH       (8),
        .STEP        (4),
        .RESET_VECTOR(8'hF8),
        .TRAP_VECTOR (8'h10)
    ) dut8 (
        .clk         (clk),
        .reset       (reset8),
        .stall       (stall8),
        .load        (load8),
        .target      (target8),
        .trap        (trap8),
        .out         (out8),
        .pc_plus_step(pc_plus_step8),
        .valid       (valid8),
        .misaligned  (misaligned8),
        .fetch_count (fetch_count8)
    );

    typedef struct {
        logic        stall;
        logic        load;
        logic        trap;
        logic [31:0] target;
        logic [31:0] exp_out;
        logic        exp_valid;
        logic [31:0] exp_fc;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic step_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          stall  load   trap   target        out           valid  fc
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004, 1'b1, 32'd1};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0008, 1'b1, 32'd2};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_000C, 1'b1, 32'd3};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0010, 1'b1, 32'd4};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0010, 1'b1, 32'd4};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0010, 1'b1, 32'd4};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0010, 1'b1, 32'd4};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_0200, 1'b0, 32'd5};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0200, 1'b1, 32'd5};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0204, 1'b1, 32'd6};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h0000_0100, 1'b0, 32'd7};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0040, 1'b0, 32'd7};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0040, 1'b1, 32'd7};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 32'h0000_0080, 32'h0000_0080, 1'b0, 32'd7};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0080, 1'b1, 32'd7};
        vecs[16] = '{1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0100, 1'b0, 32'd7};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0100, 1'b1, 32'd7};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0104, 1'b1, 32'd8};

        // Reset state while still held in reset
        #3;
        check("rst_out", out, 32'h0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_fc", fetch_count, 32'd0);
        check("rst_misaligned", 32'(misaligned), 32'd0);
        check("rst_pc_plus_step", pc_plus_step, 32'h4);

        #2 reset = 1'b1;
        #1;
        check("boot_out", out, 32'h0);
        check("boot_valid", 32'(valid), 32'd0);

        for (int i = 0; i < 19; i++) begin
            stall  = vecs[i].stall;
            load   = vecs[i].load;
            trap   = vecs[i].trap;
            target = vecs[i].target;
            step_edge();
            check($sformatf("vec%0d_out", i), out, vecs[i].exp_out);
            check($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_fc", i), fetch_count, vecs[i].exp_fc);
            check($sformatf("vec%0d_pps", i), pc_plus_step, vecs[i].exp_out + 32'd4);
            check($sformatf("vec%0d_misaligned", i), 32'(misaligned), 32'd0);
        end
        stall = 1'b0; load = 1'b0; trap = 1'b0; target = '0;

        // 8-bit instance: wrap from 0xFC to 0x00 without any flag
        #2 reset8 = 1'b1;
        step_edge();
        check("w8_boot_out", 32'(out8), 32'h0000_00F8);
        check("w8_boot_valid", 32'(valid8), 32'd1);
        step_edge();
        check("w8_fc_out", 32'(out8), 32'h0000_00FC);
        check("w8_fc_pps", 32'(pc_plus_step8), 32'h0000_0000);
        step_edge();
        check("w8_wrap_out", 32'(out8), 32'h0000_0000);
        check("w8_wrap_pps", 32'(pc_plus_step8), 32'h0000_0004);
        check("w8_wrap_fc", 32'(fetch_count8), 32'd2);
        check("w8_wrap_misaligned", 32'(misaligned8), 32'd0);
        check("w8_wrap_valid", 32'(valid8), 32'd1);

        // Unaligned load target (state is RUN, out=0x110 at this point)
        load = 1'b1; target = 32'h0000_0202;
        step_edge();
        load = 1'b0; target = '0;
`ifdef PC_MISALIGN_CHECK_EN
        check("mis_out", out, 32'h0000_0100);
        check("mis_flag", 32'(misaligned), 32'd1);
        step_edge();
        check("mis_hold", 32'(misaligned), 32'd1);
        load = 1'b1; target = 32'h0000_0400;
        step_edge();
        load = 1'b0; target = '0;
        check("mis_clear_out", out, 32'h0000_0400);
        check("mis_clear_flag", 32'(misaligned), 32'd0);
`else
        check("unal_out", out, 32'h0000_0202);
        check("unal_flag", 32'(misaligned), 32'd0);
`endif
        check("redir_valid", 32'(valid), 32'd0);
        step_edge();
        check("post_redir_valid", 32'(valid), 32'd1);

        // Reset asserted while in BUBBLE takes effect before the next edge
        load = 1'b1; target = 32'h0000_0500;
        step_edge();
        load = 1'b0; target = '0;
        check("bub_out", out, 32'h0000_0500);
        check("bub_valid", 32'(valid), 32'd0);
        #2 reset = 1'b0;
        #1;
        check("async_rst_out", out, 32'h0);
        check("async_rst_valid", 32'(valid), 32'd0);
        check("async_rst_fc", fetch_count, 32'd0);
        check("async_rst_misaligned", 32'(misaligned), 32'd0);
        #2 reset = 1'b1;
        step_edge();
        check("rerelease_out", out, 32'h0);
        check("rerelease_valid", 32'(valid), 32'd1);
        check("rerelease_fc", fetch_count, 32'd0);
        step_edge();
        check("rerun_out", out, 32'h4);
        check("rerun_fc", fetch_count, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pc_counter.md
# pc_counter

Parametrised program-counter generator for the RISC-V processor core; it generalises the free-running 32-bit counter into a fetch-address source. It holds the current fetch PC, advances by a configurable step, and accepts stall, branch/jump redirect and trap redirect. It also keeps a retired-fetch count. It sits between the fetch stage (instruction-memory address) and the execute/branch unit.

## Interface
- WIDTH, 32: PC and counter width in bits.
- STEP, 4: increment per advance, in bytes.
- RESET_VECTOR, 32'h0000_0000: PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100: PC loaded on a trap.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hold the PC; no advance.
- load  in  1  branch/jump taken; redirect to `target`.
- target  in  WIDTH  redirect address.
- trap  in  1  exception; redirect to TRAP_VECTOR.
- out  out  WIDTH  current fetch PC.
- pc_plus_step  out  WIDTH  out + STEP, modulo 2^WIDTH (combinational).
- valid  out  1  `out` is a fetchable address this cycle.
- misaligned  out  1  last redirect target was not STEP-aligned (see Configuration).
- fetch_count  out  WIDTH  number of cycles with valid=1 and stall=0.

## Operation
- States:
  - BOOT: first cycle after reset release.
  - RUN: normal operation.
  - BUBBLE: one flush cycle after any redirect.
- Transitions:
  - BOOT goes to RUN unconditionally.
  - RUN goes to BUBBLE on load or trap; otherwise it stays in RUN.
  - BUBBLE goes to RUN, unless a new load or trap arrives, in which case it stays in BUBBLE.
- Priority each cycle: trap > load > stall > increment.
- trap sets out to TRAP_VECTOR and load sets out to target. Both are honoured even when stall=1.
- Increment: when state=RUN and stall=0, out becomes out+STEP. This wraps modulo 2^WIDTH, so 0xFFFF_FFFC+4 becomes 0x0000_0000, with no flag.
- In BOOT and BUBBLE, out holds and valid=0.
- fetch_count increments when valid=1 and stall=0, and wraps modulo 2^WIDTH.
- Reset (asynchronous, any time, including mid-redirect):
  - out=RESET_VECTOR, valid=0, misaligned=0, fetch_count=0, state=BOOT.

## Timing
- Redirect latency: load or trap sampled at edge N gives the new out after edge N. valid=0 for that cycle, and valid=1 from edge N+1 onwards.
- Stall is zero-latency: a stall sampled at edge N leaves out unchanged after edge N.
- valid is low for exactly one cycle after reset release, then follows the state machine.
- pc_plus_step is purely combinational from out.
- Simultaneous load and trap: trap wins and target is ignored.
- load during BUBBLE: out takes the new target and BUBBLE is extended by one cycle.

## Configuration
- PC_MISALIGN_CHECK_EN defined:
  - A load whose target is not a multiple of STEP redirects to TRAP_VECTOR instead of target.
  - misaligned is set to 1 at the same edge and stays 1 until the next accepted aligned load, trap, or reset.
- PC_MISALIGN_CHECK_EN undefined:
  - target is loaded as given, misaligned is tied to 0, and the check logic is absent.

## Structure
- Shared package pc_pkg holds:
  - the state encoding constants (BOOT=2'd0, RUN=2'd1, BUBBLE=2'd2);
  - the default RESET_VECTOR, TRAP_VECTOR and STEP constants, shared with the fetch stage.
- Sub-module up_counter (parameter WIDTH; ports clk, reset, inc, count) implements fetch_count. It is reused for later performance counters.

## Test plan
- Reset released at t=5 with defaults, no stall/load/trap:
  - out=0x0 and valid=0 for the first cycle;
  - then out=0x4, 0x8, 0xC on successive edges;
  - fetch_count=3 after four edges.
- stall=1 for 3 cycles with out=0x10: out stays 0x10, fetch_count frozen, valid=1.
- load=1, target=0x200 with out=0x10:
  - next cycle out=0x200, valid=0;
  - following cycle valid=1, then out=0x204.
- load=1 (target=0x300) and trap=1 together: out=0x100 and target is ignored.
- WIDTH=8, STEP=4, out=0xFC, run one edge: out=0x00, with no error flag.
- PC_MISALIGN_CHECK_EN defined, load target=0x202:
  - out=0x100 and misaligned=1;
  - a subsequent load to 0x400 clears misaligned.
- reset asserted while in BUBBLE: out=RESET_VECTOR immediately (before the next edge), and valid=0.
